// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// FSM state encoding and a flag-packing helper.
package alu_pkg;

  localparam int OPW = 4;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_PASSB = 4'd0;
  localparam opcode_t OP_ADD   = 4'd1;
  localparam opcode_t OP_SUB   = 4'd2;
  localparam opcode_t OP_AND   = 4'd3;
  localparam opcode_t OP_OR    = 4'd4;
  localparam opcode_t OP_XOR   = 4'd5;
  localparam opcode_t OP_SHL   = 4'd6;
  localparam opcode_t OP_SHR   = 4'd7;
  localparam opcode_t OP_MUL   = 4'd8;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one iteration per clock, WIDTH iterations
// after load. product shows the accumulator value after the current iteration.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               active_q;

  // Exposing the post-iteration sum lets the owner capture the final product
  // on the same edge as the WIDTH-th iteration.
  assign product = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign last    = active_q && (cnt_q == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with condition flags and a multi-cycle multiply
// behind a start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               done_q;

  logic               load;
  logic               wr;
  logic [WIDTH-1:0]   wr_result;
  logic               wr_c, wr_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] product;
  logic               mul_last;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .a       (a),
    .b       (b),
    .product (product),
    .last    (mul_last)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_PASSB: alu_res = b;
      OP_ADD: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff[MSB:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  {alu_c, alu_res} = {a, 1'b0};
      OP_SHR:  {alu_res, alu_c} = {1'b0, a};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    wr        = 1'b0;
    wr_result = alu_res;
    wr_c      = alu_c;
    wr_v      = alu_v;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            load    = 1'b1;
            state_d = MUL;
          end else begin
            wr = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_last) begin
          wr        = 1'b1;
          wr_result = product[MSB:0];
          wr_c      = |product[2*WIDTH-1:WIDTH];
          wr_v      = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wr;
      if (wr) begin
        result_q <= wr_result;
        flags_q  <= pack_flags(wr_result == '0, wr_c, wr_result[MSB], wr_v);
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = (state_q == MUL);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops
// compared with an arithmetic reference model.
module tb_alu_seq;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = MOD / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_result = '0;
  logic [3:0]       exp_flags  = '0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .flags  (flags),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: returns {V,N,C,Z, result} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input logic [3:0] o, input logic [7:0] xa,
                                          input logic [7:0] ya);
    int x, y, r, sx, sy, s;
    logic c, v;
    x = int'(xa);
    y = int'(ya);
    sx = (x >= HALF) ? x - MOD : x;
    sy = (y >= HALF) ? y - MOD : y;
    c = 1'b0;
    v = 1'b0;
    case (int'(o))
      0: r = y;
      1: begin r = x + y; c = (r >= MOD); s = sx + sy; v = (s >= HALF) || (s < -HALF); end
      2: begin r = x - y; c = (x < y);    s = sx - sy; v = (s >= HALF) || (s < -HALF); end
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: begin r = x * 2; c = (x >= HALF); end
      7: begin r = x / 2; c = (x % 2) == 1; end
      8: begin r = x * y; c = (r >= MOD); end
      default: r = 0;
    endcase
    r = r & (MOD - 1);
    return {v, (r >= HALF), c, (r == 0), 8'(r)};
  endfunction

  task automatic single_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input logic [3:0] ef);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    check($sformatf("op%0d busy/done", o), {busy, done}, 2'b01);
    check($sformatf("op%0d result", o), result, er);
    check($sformatf("op%0d flags", o), flags, ef);
    @(negedge clk);
    check($sformatf("op%0d done_pulse", o), done, 1'b0);
    check($sformatf("op%0d hold", o), {flags, result}, {ef, er});
    exp_result = er;
    exp_flags  = ef;
  endtask

  task automatic mul_op(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef, input bit inject);
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = x; b = y;
    for (int i = 1; i <= WIDTH; i++) begin
      @(negedge clk);
      start = inject && (i == 3);
      op = start ? 4'd1 : 4'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      check("mul busy/done", {busy, done}, 2'b10);
      check("mul hold", {flags, result}, {exp_flags, exp_result});
    end
    @(negedge clk);
    start = 1'b0;
    check("mul busy/done end", {busy, done}, 2'b01);
    check("mul result", result, er);
    check("mul flags", flags, ef);
    @(negedge clk);
    check("mul done_pulse", {busy, done}, 2'b00);
    exp_result = er;
    exp_flags  = ef;
  endtask

  initial begin
    logic [11:0] m;
    logic [3:0]  o;
    logic [7:0]  x, y;
    bit          saw_done;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset state", {busy, done, flags, result}, 14'h0);

    // Carry out with zero result.
    single_op(4'd1, 8'hFF, 8'h01, 8'h00, 4'b0011);

    // Back-to-back ADD then SUB.
    @(negedge clk);
    start = 1'b1; op = 4'd1; a = 8'h7F; b = 8'h01;
    @(negedge clk);
    op = 4'd2; a = 8'h05; b = 8'h07;
    check("b2b add done", done, 1'b1);
    check("b2b add", {flags, result}, {4'b1100, 8'h80});
    @(negedge clk);
    start = 1'b0;
    check("b2b sub done", done, 1'b1);
    check("b2b sub", {flags, result}, {4'b0110, 8'hFE});
    @(negedge clk);
    check("b2b done drop", done, 1'b0);
    exp_result = 8'hFE;
    exp_flags  = 4'b0110;

    mul_op(8'h0C, 8'h0B, 8'h84, 4'b0100, 1'b0);
    mul_op(8'h10, 8'h10, 8'h00, 4'b0011, 1'b1);

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = 8'hFF; b = 8'hFF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort busy", {busy, done}, 2'b10);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort state", {busy, done, flags, result}, 14'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      saw_done |= done | busy;
    end
    check("abort no done", saw_done, 1'b0);
    exp_result = '0;
    exp_flags  = '0;
    single_op(4'd1, 8'h02, 8'h03, 8'h05, 4'b0000);

    for (int k = 9; k <= 15; k++) single_op(4'(k), 8'hAA, 8'h55, 8'h00, 4'b0001);
    single_op(4'd0, 8'h3C, 8'h80, 8'h80, 4'b0100);

    for (int k = 0; k < 150; k++) begin
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom);
      y = 8'($urandom);
      m = ref_alu(o, x, y);
      if (o == 4'd8) mul_op(x, y, m[7:0], m[11:8], bit'($urandom_range(0, 1)));
      else           single_op(o, x, y, m[7:0], m[11:8]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU; the next generation of the processor datapath ALU.
- Generalises the 8-bit pass/add unit to WIDTH bits and a 16-entry opcode space.
- Adds a registered condition-flag set (Z, C, N, V) and a multi-cycle shift-add multiply.
- A start/busy/done handshake lets the control unit stall on multi-cycle ops.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- OPW, 4, opcode width; fixed at 4, exposed only for the package.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled in IDLE only
- op  input  OPW  opcode, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- result  output  WIDTH  registered result
- flags  output  4  registered {V,N,C,Z}; bit0=Z, bit1=C, bit2=N, bit3=V
- busy  output  1  high while a multi-cycle op is in progress
- done  output  1  one-cycle pulse when result/flags are updated

Behaviour:
- Reset (rst high at an edge) forces result=0, flags=0, busy=0, done=0, state=IDLE, multiplier cleared. Reset wins over every other event, including mid-MUL: the op is aborted and no done is issued.
- States: IDLE, MUL.
- IDLE with start=1 and a single-cycle op (opcode ≠ 8):
  - result and flags are written at that edge.
  - done=1 for the following cycle only. Latency is 1 cycle.
  - State stays IDLE, so back-to-back starts on consecutive cycles are accepted, one done per start.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0 PASSB: result=b.
  - 1 ADD: result=a+b; C=carry out; V=signed overflow.
  - 2 SUB: result=a-b; C=borrow (1 when a<b unsigned); V=signed overflow.
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SHL: result=a<<1; C=a[WIDTH-1].
  - 7 SHR (logical): result=a>>1; C=a[0].
  - 8 MUL: unsigned a*b.
  - 9–15 reserved: result=0.
- Flag rules:
  - Z=(result==0) and N=result[WIDTH-1] for every op.
  - C=0 for PASSB, logic ops and reserved codes.
  - V=0 for every op except ADD and SUB.
- Flags change only when done is asserted; otherwise they hold.
- IDLE with start=1 and op=8:
  - Operands are latched; state goes to MUL; busy=1 from the next cycle.
  - A shift-add multiplier runs exactly WIDTH iterations, one per clock, using a 2·WIDTH-bit product.
  - At the WIDTH-th iteration edge: result=product[WIDTH-1:0]; C=|product[2W-1:W] (truncation indicator); V=0; busy=0; done=1 the next cycle; return to IDLE.
  - Timing: start sampled at edge N → done high in the cycle after edge N+WIDTH.
- start while busy: ignored entirely (no queueing, no effect on operands or result).
- Inputs a, b and op may change freely during MUL; the latched copies are used.
- busy and done are never high in the same cycle.

Decomposition:
- alu_pkg holds:
  - Opcode localparams OP_PASSB … OP_MUL.
  - Flag bit indices FLAG_Z/C/N/V.
  - State encoding IDLE/MUL.
- One sub-module, alu_mul_seq, with ports clk, rst, load, a, b, product, last. It is a WIDTH-parametrised shift-add unit with an iteration counter of clog2(WIDTH)+1 bits.
- alu_seq keeps the opcode decode, flag logic and FSM.

Test Plan (WIDTH=8):
- ADD a=0xFF, b=0x01 → next cycle result=0x00, Z=1, C=1, N=0, V=0, done pulse of exactly 1 cycle.
- ADD a=0x7F, b=0x01, then SUB a=0x05, b=0x07 on the next cycle → result=0x80 with V=1, N=1, C=0; then result=0xFE with C=1, N=1, V=0. Two done pulses on consecutive cycles.
- MUL a=0x0C, b=0x0B → busy high for 8 cycles; result=0x84, C=0, Z=0, N=1; done in the cycle after edge N+8. Flags unchanged until then.
- MUL a=0x10, b=0x10 → result=0x00, Z=1, C=1. Assert start with op=ADD mid-MUL → ignored; result still 0x00 and only one done pulse.
- rst asserted at iteration 4 of a MUL → next cycle busy=0, done=0, result=0, flags=0. No done ever appears; a fresh ADD 0x02+0x03 then returns 0x05.
- Sweep: op=9..15 with a=0xAA, b=0x55 → result=0x00, flags=0x1 (Z only). Then PASSB b=0x80 → result=0x80, N=1, C=0.
